fp_accumulator: RTL and testbench

Sequential IEEE-754 single-precision accumulator that sits directly downstream of the combinational `mult` stage and sums its products into a running total. It accepts one 32-bit product per valid/ready handshake, aligns, adds and normalises over several cycles, and publishes the updated total with a one-cycle valid pulse. Together with `mult` it forms the multiply-accumulate path of the floating-point ALU.

---
 rtl/fp_accumulator_if.sv | 16 +
 rtl/fp_accumulator.sv | 190 +++++++++++++++++++
 tb/tb_fp_accumulator.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_accumulator_if.sv
// Handshake and result bundle between the mult stage (master) and fp_accumulator (slave).
interface fp_accumulator_if;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] acc;
    logic        acc_valid;
    logic        ovf;
    logic        busy;

    modport master (output clr, in_valid, in_data,
                    input  in_ready, acc, acc_valid, ovf, busy);
    modport slave  (input  clr, in_valid, in_data,
                    output in_ready, acc, acc_valid, ovf, busy);
endinterface

// File: rtl/fp_accumulator.sv
// Multi-cycle IEEE-754 single-precision accumulator: align, add, then normalise one bit per cycle.
// Denormal inputs flush to +0, alignment truncates, and overflow saturates to the largest finite value.
module fp_accumulator (
    input  logic             clk,
    input  logic             rst_n,
    fp_accumulator_if.slave  io_bus
);
    typedef enum logic [1:0] {IDLE, ALIGN, ADD, NORM} state_t;

    state_t      r_state;
    state_t      w_stateNext;

    logic [31:0] r_acc;
    logic        r_accValid;
    logic        r_ovf;

    logic        r_opSign;
    logic [7:0]  r_opExp;
    logic [23:0] r_opMan;

    logic        r_resSign;
    logic [7:0]  r_resExp;
    logic [23:0] r_bigMan;
    logic [23:0] r_smallMan;
    logic        r_subtract;
    logic [24:0] r_sum;

    logic        w_accept;
    logic        w_special;
    logic        w_accSign;
    logic [7:0]  w_accExp;
    logic [23:0] w_accMan;
    logic        w_opBigger;
    logic [7:0]  w_bigExp;
    logic [7:0]  w_expDiff;
    logic [23:0] w_smallRaw;
    logic [23:0] w_shifted;
    logic [24:0] w_addSum;
    logic        w_normDone;
    logic        w_normOvf;
    logic [31:0] w_normResult;
    logic [24:0] w_normSum;
    logic [7:0]  w_normExp;

    // The stored total is always normalised, zero or saturated, so the hidden bit follows the exponent.
    assign w_accSign = r_acc[31];
    assign w_accExp  = r_acc[30:23];
    assign w_accMan  = (w_accExp == 8'd0) ? 24'd0 : {1'b1, r_acc[22:0]};

    assign w_opBigger = {r_opExp, r_opMan} > {w_accExp, w_accMan};
    assign w_bigExp   = w_opBigger ? r_opExp : w_accExp;
    assign w_expDiff  = w_opBigger ? (r_opExp - w_accExp) : (w_accExp - r_opExp);
    assign w_smallRaw = w_opBigger ? w_accMan : r_opMan;
    assign w_shifted  = (w_expDiff >= 8'd25) ? 24'd0 : (w_smallRaw >> w_expDiff);

    assign w_addSum = r_subtract ? ({1'b0, r_bigMan} - {1'b0, r_smallMan})
                                 : ({1'b0, r_bigMan} + {1'b0, r_smallMan});

    always_comb begin
        w_normDone   = 1'b0;
        w_normOvf    = 1'b0;
        w_normResult = 32'd0;
        w_normSum    = r_sum;
        w_normExp    = r_resExp;
        if (r_sum == 25'd0) begin
            w_normDone = 1'b1;
        end else if (r_sum[24]) begin
            if (r_resExp == 8'd254) begin
                w_normDone   = 1'b1;
                w_normOvf    = 1'b1;
                w_normResult = {r_resSign, 31'h7F7FFFFF};
            end else begin
                w_normSum = r_sum >> 1;
                w_normExp = r_resExp + 8'd1;
            end
        end else if (r_sum[23]) begin
            w_normDone   = 1'b1;
            w_normResult = {r_resSign, r_resExp, r_sum[22:0]};
        end else if (r_resExp == 8'd1) begin
            // One more left shift would underflow the exponent, so the result flushes to +0.
            w_normDone = 1'b1;
        end else begin
            w_normSum = r_sum << 1;
            w_normExp = r_resExp - 8'd1;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        w_special   = 1'b0;
        if (io_bus.clr) begin
            w_stateNext = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (io_bus.in_valid) begin
                        w_accept = 1'b1;
                        if (io_bus.in_data[30:23] == 8'hFF) begin
                            w_special = 1'b1;
                        end else begin
                            w_stateNext = ALIGN;
                        end
                    end
                end
                ALIGN:   w_stateNext = ADD;
                ADD:     w_stateNext = NORM;
                NORM:    w_stateNext = w_normDone ? IDLE : NORM;
                default: w_stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= 32'd0;
            r_accValid <= 1'b0;
            r_ovf      <= 1'b0;
            r_opSign   <= 1'b0;
            r_opExp    <= 8'd0;
            r_opMan    <= 24'd0;
            r_resSign  <= 1'b0;
            r_resExp   <= 8'd0;
            r_bigMan   <= 24'd0;
            r_smallMan <= 24'd0;
            r_subtract <= 1'b0;
            r_sum      <= 25'd0;
        end else begin
            r_accValid <= 1'b0;
            if (io_bus.clr) begin
                r_acc <= 32'd0;
                r_ovf <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_special) begin
                            r_ovf      <= 1'b1;
                            r_accValid <= 1'b1;
                        end else if (w_accept) begin
                            r_opExp <= io_bus.in_data[30:23];
                            if (io_bus.in_data[30:23] == 8'd0) begin
                                r_opSign <= 1'b0;
                                r_opMan  <= 24'd0;
                            end else begin
                                r_opSign <= io_bus.in_data[31];
                                r_opMan  <= {1'b1, io_bus.in_data[22:0]};
                            end
                        end
                    end
                    ALIGN: begin
                        r_resSign  <= w_opBigger ? r_opSign : w_accSign;
                        r_resExp   <= w_bigExp;
                        r_bigMan   <= w_opBigger ? r_opMan : w_accMan;
                        r_smallMan <= w_shifted;
                        r_subtract <= r_opSign ^ w_accSign;
                    end
                    ADD: begin
                        r_sum <= w_addSum;
                    end
                    NORM: begin
                        r_sum    <= w_normSum;
                        r_resExp <= w_normExp;
                        if (w_normDone) begin
                            r_acc      <= w_normResult;
                            r_accValid <= 1'b1;
                            if (w_normOvf) begin
                                r_ovf <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign io_bus.in_ready  = (r_state == IDLE) && !io_bus.clr;
    assign io_bus.busy      = (r_state != IDLE);
    assign io_bus.acc       = r_acc;
    assign io_bus.acc_valid = r_accValid;
    assign io_bus.ovf       = r_ovf;
endmodule

// File: tb/tb_fp_accumulator.sv
// Self-checking bench for fp_accumulator: directed vector table, randomized run against an
// arithmetic reference model, and hand-written reset/clear sequences.
module tb_fp_accumulator;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;

    fp_accumulator_if bus ();

    fp_accumulator dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          clearFirst;
        logic [31:0] operand;
        logic [31:0] expAcc;
        bit          expOvf;
        int          expLat;
    } vector_t;

    vector_t     vectors[19];
    logic [31:0] accOut;
    logic [31:0] modelAcc;
    logic [31:0] expAcc;
    logic [31:0] operand;
    logic        ovfOut;
    bit          modelOvf;
    bit          sat;
    int          lat;
    int          expLat;
    int          pulses;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Reference sum from the numeric rules: magnitude compare, truncating align, closed-form normalise.
    function automatic void refAdd(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] result, output bit saturated, output int latency);
        int expA, expB, expBig, expSmall, diff, shifts, normCycles;
        int manA, manB, manBig, manSmall, sum;
        bit signA, signB, signBig;
        saturated = 1'b0;
        if (b[30:23] == 8'hFF) begin
            result  = a;
            saturated = 1'b1;
            latency = 1;
            return;
        end
        expA  = int'(a[30:23]);
        expB  = int'(b[30:23]);
        manA  = (expA == 0) ? 0 : (1 << 23) + int'(a[22:0]);
        manB  = (expB == 0) ? 0 : (1 << 23) + int'(b[22:0]);
        signA = (expA != 0) && a[31];
        signB = (expB != 0) && b[31];
        if (expB > expA || (expB == expA && manB > manA)) begin
            expBig = expB; manBig = manB; signBig = signB; expSmall = expA; manSmall = manA;
        end else begin
            expBig = expA; manBig = manA; signBig = signA; expSmall = expB; manSmall = manB;
        end
        diff = expBig - expSmall;
        manSmall = (diff >= 25) ? 0 : (manSmall >> diff);
        sum = (signA == signB) ? manBig + manSmall : manBig - manSmall;
        normCycles = 1;
        if (sum == 0) begin
            result = 32'd0;
        end else if (sum >= (1 << 24)) begin
            if (expBig + 1 >= 255) begin
                result = {signBig, 31'h7F7FFFFF};
                saturated = 1'b1;
            end else begin
                result = {signBig, 8'(expBig + 1), 23'(sum >> 1)};
                normCycles = 2;
            end
        end else begin
            shifts = 0;
            while (sum < (1 << 23)) begin
                sum = sum * 2;
                shifts++;
            end
            if (shifts >= expBig) begin
                result = 32'd0;
                normCycles = expBig;
            end else begin
                result = {signBig, 8'(expBig - shifts), 23'(sum)};
                normCycles = shifts + 1;
            end
        end
        latency = 3 + normCycles;
    endfunction

    function automatic logic [31:0] randomOperand(input logic [31:0] current);
        logic [7:0] e;
        int sel;
        sel = int'($urandom_range(0, 15));
        case (sel)
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       e = 8'hFE;
            3:       e = 8'($urandom_range(1, 3));
            4:       return {~current[31], current[30:0]};
            5:       return {~current[31], current[30:3], 3'($urandom)};
            default: e = 8'($urandom_range(118, 136));
        endcase
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    task automatic clearAcc();
        @(negedge clk);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
    endtask

    // Returns at the first falling edge after the accepting rising edge (cycle T+1).
    task automatic startOperand(input logic [31:0] data);
        int waitCycles = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        while (!bus.in_ready && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("in_ready_at_handshake", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
    endtask

    task automatic waitResult(output int latency);
        latency = 1;
        while (!bus.acc_valid && latency < 40) begin
            @(negedge clk);
            latency++;
        end
        if (!bus.acc_valid) begin
            checkOutput("acc_valid_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] data, output logic [31:0] accResult,
                                 output logic ovfResult, output int latency);
        startOperand(data);
        waitResult(latency);
        accResult = bus.acc;
        ovfResult = bus.ovf;
        @(negedge clk);
        checkOutput("acc_valid_single_pulse", 32'(bus.acc_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        bus.clr      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 32'd0;

        vectors[0]  = '{1'b1, 32'h3FC00000, 32'h3FC00000, 1'b0, 4};
        vectors[1]  = '{1'b0, 32'h40200000, 32'h40800000, 1'b0, 5};
        vectors[2]  = '{1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 4};
        vectors[3]  = '{1'b0, 32'hBF7FFFFF, 32'h34000000, 1'b0, 27};
        vectors[4]  = '{1'b1, 32'h40000000, 32'h40000000, 1'b0, 4};
        vectors[5]  = '{1'b0, 32'hC0000000, 32'h00000000, 1'b0, 4};
        vectors[6]  = '{1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 4};
        vectors[7]  = '{1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 4};
        vectors[8]  = '{1'b1, 32'h7F800000, 32'h00000000, 1'b1, 1};
        vectors[9]  = '{1'b1, 32'h00400000, 32'h00000000, 1'b0, 4};
        vectors[10] = '{1'b1, 32'hC0400000, 32'hC0400000, 1'b0, 4};
        vectors[11] = '{1'b0, 32'h3F800000, 32'hC0000000, 1'b0, 4};
        vectors[12] = '{1'b1, 32'h00800000, 32'h00800000, 1'b0, 4};
        vectors[13] = '{1'b0, 32'h80C00000, 32'h00000000, 1'b0, 4};
        vectors[14] = '{1'b1, 32'h4B800000, 32'h4B800000, 1'b0, 4};
        vectors[15] = '{1'b0, 32'h3F800000, 32'h4B800000, 1'b0, 4};
        vectors[16] = '{1'b1, 32'h4B000000, 32'h4B000000, 1'b0, 4};
        vectors[17] = '{1'b0, 32'h3F800000, 32'h4B000001, 1'b0, 4};
        vectors[18] = '{1'b0, 32'hFF800000, 32'h4B000001, 1'b1, 1};

        #7;
        checkOutput("reset_acc", bus.acc, 32'd0);
        checkOutput("reset_acc_valid", 32'(bus.acc_valid), 32'd0);
        checkOutput("reset_ovf", 32'(bus.ovf), 32'd0);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed vector table");
        for (int i = 0; i < $size(vectors); i++) begin
            if (vectors[i].clearFirst) begin
                clearAcc();
                checkOutput($sformatf("vec%0d_clear_acc", i), bus.acc, 32'd0);
                checkOutput($sformatf("vec%0d_clear_ovf", i), 32'(bus.ovf), 32'd0);
            end
            applyStimulus(vectors[i].operand, accOut, ovfOut, lat);
            checkOutput($sformatf("vec%0d_acc", i), accOut, vectors[i].expAcc);
            checkOutput($sformatf("vec%0d_ovf", i), 32'(ovfOut), 32'(vectors[i].expOvf));
            checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vectors[i].expLat));
        end

        $display("[TB] randomized accumulation against reference model");
        clearAcc();
        modelAcc = 32'd0;
        modelOvf = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                clearAcc();
                modelAcc = 32'd0;
                modelOvf = 1'b0;
            end
            operand = randomOperand(modelAcc);
            refAdd(modelAcc, operand, expAcc, sat, expLat);
            modelAcc = expAcc;
            modelOvf = modelOvf | sat;
            applyStimulus(operand, accOut, ovfOut, lat);
            checkOutput($sformatf("rand%0d_acc(op=%h)", i, operand), accOut, modelAcc);
            checkOutput($sformatf("rand%0d_ovf", i), 32'(ovfOut), 32'(modelOvf));
            checkOutput($sformatf("rand%0d_latency", i), 32'(lat), 32'(expLat));
        end

        $display("[TB] reset during normalisation");
        clearAcc();
        applyStimulus(32'h3F800000, accOut, ovfOut, lat);
        applyStimulus(32'h7F800000, accOut, ovfOut, lat);
        checkOutput("pre_reset_ovf", 32'(ovfOut), 32'd1);
        startOperand(32'hBF7FFFFF);
        repeat (8) @(negedge clk);
        checkOutput("pre_reset_busy", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_acc", bus.acc, 32'd0);
        checkOutput("async_reset_acc_valid", 32'(bus.acc_valid), 32'd0);
        checkOutput("async_reset_ovf", 32'(bus.ovf), 32'd0);
        checkOutput("async_reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("async_reset_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("post_reset_acc", bus.acc, 32'd0);
        applyStimulus(32'h3FC00000, accOut, ovfOut, lat);
        checkOutput("post_reset_add_acc", accOut, 32'h3FC00000);
        checkOutput("post_reset_add_latency", 32'(lat), 32'd4);

        $display("[TB] clear during ADD");
        clearAcc();
        applyStimulus(32'h3F800000, accOut, ovfOut, lat);
        startOperand(32'h40000000);
        @(negedge clk);
        checkOutput("busy_in_add", 32'(bus.busy), 32'd1);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_acc", bus.acc, 32'd0);
        checkOutput("abort_acc_valid", 32'(bus.acc_valid), 32'd0);
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.acc_valid) pulses++;
        end
        checkOutput("abort_no_pulse", 32'(pulses), 32'd0);

        $display("[TB] clear together with in_valid");
        applyStimulus(32'h3F800000, accOut, ovfOut, lat);
        checkOutput("pre_clr_acc", accOut, 32'h3F800000);
        @(negedge clk);
        bus.clr      = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h40400000;
        #1;
        checkOutput("clr_blocks_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        bus.clr = 1'b0;
        checkOutput("clr_only_acc", bus.acc, 32'd0);
        checkOutput("clr_only_not_busy", 32'(bus.busy), 32'd0);
        #1;
        checkOutput("ready_after_clr", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        checkOutput("accepted_after_clr", 32'(bus.busy), 32'd1);
        bus.in_valid = 1'b0;
        waitResult(lat);
        checkOutput("after_clr_acc", bus.acc, 32'h40400000);
        checkOutput("after_clr_latency", 32'(lat), 32'd4);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
